// File: rtl/crc_frame_serializer.sv
// Byte-to-bit serializer feeding the serial CRC stage; optional SER_MSB_FIRST_EN selects MSB-first order.
// Latency: first bit on DATA one edge after the handshake; CRC_WIDTH-cycle gap after the frame.
// Backpressure: P_READY only in IDLE or on the final bit of a non-last word; a frame never stalls.
module crc_frame_serializer #(
    parameter int DATA_WIDTH = 8,
    parameter int CRC_WIDTH  = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [DATA_WIDTH-1:0] P_DATA,
    input  logic                  P_VALID,
    input  logic                  P_LAST,
    output logic                  P_READY,
    output logic                  ACTIVE,
    output logic                  DATA,
    output logic                  BUSY,
    output logic                  FRAME_DONE,
    output logic                  UNDERRUN
);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int GW = (CRC_WIDTH > 1) ? $clog2(CRC_WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [GW-1:0]         gap_cnt_q, gap_cnt_d;
    logic                  last_q, last_d;
    logic                  active_q, active_d;
    logic                  data_q, data_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  under_q, under_d;

    logic                  hs;
    logic                  last_bit;
    logic                  gap_end;
    logic                  first_bit;
    logic                  out_bit;
    logic [DATA_WIDTH-1:0] load_val;
    logic [DATA_WIDTH-1:0] shift_val;

    // The shift register holds only the bits not yet driven onto DATA.
`ifdef SER_MSB_FIRST_EN
    assign first_bit = P_DATA[DATA_WIDTH-1];
    assign load_val  = P_DATA << 1;
    assign out_bit   = sreg_q[DATA_WIDTH-1];
    assign shift_val = sreg_q << 1;
`else
    assign first_bit = P_DATA[0];
    assign load_val  = P_DATA >> 1;
    assign out_bit   = sreg_q[0];
    assign shift_val = sreg_q >> 1;
`endif

    assign last_bit = (bit_cnt_q == BW'(DATA_WIDTH - 1));
    assign gap_end  = (gap_cnt_q == GW'(CRC_WIDTH - 1));
    assign P_READY  = (state_q == IDLE) || ((state_q == SHIFT) && last_bit && !last_q);
    assign hs       = P_VALID && P_READY;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= IDLE;
            sreg_q    <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            last_q    <= 1'b0;
            active_q  <= 1'b0;
            data_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            under_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sreg_q    <= sreg_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            last_q    <= last_d;
            active_q  <= active_d;
            data_q    <= data_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            under_q   <= under_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (hs) state_d = SHIFT;
            SHIFT:   if (last_bit && !hs) state_d = GAP;
            GAP:     if (gap_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sreg_d    = sreg_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        last_d    = last_q;
        active_d  = 1'b0;
        data_d    = 1'b0;
        done_d    = 1'b0;
        under_d   = 1'b0;
        busy_d    = (state_d != IDLE);
        if (hs) begin
            sreg_d    = load_val;
            data_d    = first_bit;
            active_d  = 1'b1;
            bit_cnt_d = '0;
            last_d    = P_LAST;
        end else if (state_q == SHIFT) begin
            if (!last_bit) begin
                sreg_d    = shift_val;
                data_d    = out_bit;
                active_d  = 1'b1;
                bit_cnt_d = bit_cnt_q + BW'(1);
            end else begin
                // Frame ends here; a missing word on a non-last frame is an underrun.
                gap_cnt_d = '0;
                under_d   = !last_q;
            end
        end else if (state_q == GAP) begin
            gap_cnt_d = gap_cnt_q + GW'(1);
            if (gap_end) begin
                gap_cnt_d = '0;
                done_d    = 1'b1;
            end
        end
    end

    assign ACTIVE     = active_q;
    assign DATA       = data_q;
    assign BUSY       = busy_q;
    assign FRAME_DONE = done_q;
    assign UNDERRUN   = under_q;
endmodule

// File: tb/tb_crc_frame_serializer.sv
// Bench for crc_frame_serializer: queue-based frame model checked every cycle plus hand-computed frame literals.
module tb_crc_frame_serializer;
    localparam int DW = 8;
    localparam int CW = 8;

    logic          CLK;
    logic          RST;
    logic [DW-1:0] P_DATA;
    logic          P_VALID;
    logic          P_LAST;
    logic          P_READY;
    logic          ACTIVE;
    logic          DATA;
    logic          BUSY;
    logic          FRAME_DONE;
    logic          UNDERRUN;

    crc_frame_serializer #(.DATA_WIDTH(DW), .CRC_WIDTH(CW)) dut (
        .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .P_VALID(P_VALID), .P_LAST(P_LAST),
        .P_READY(P_READY), .ACTIVE(ACTIVE), .DATA(DATA), .BUSY(BUSY),
        .FRAME_DONE(FRAME_DONE), .UNDERRUN(UNDERRUN)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    // Model: a queue of bits still to appear on DATA, plus a countdown of gap cycles.
    bit m_q[$];
    bit m_act = 0, m_data = 0, m_done = 0, m_und = 0, m_last = 0, m_hs = 0;
    int m_gap = 0;

    function automatic bit m_ready();
        return (!m_act && m_gap == 0) || (m_act && m_q.size() == 0 && !m_last);
    endfunction

    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            m_q.delete();
            m_act = 0; m_data = 0; m_done = 0; m_und = 0; m_last = 0; m_gap = 0;
        end else begin
            m_hs = P_VALID && m_ready();
            if (m_hs) begin
`ifdef SER_MSB_FIRST_EN
                for (int i = DW - 1; i >= 0; i--) m_q.push_back(P_DATA[i]);
`else
                for (int i = 0; i < DW; i++) m_q.push_back(P_DATA[i]);
`endif
                m_last = P_LAST;
            end
            m_done = 0;
            m_und  = 0;
            if (m_q.size() > 0) begin
                m_act  = 1;
                m_data = m_q.pop_front();
            end else if (m_act) begin
                m_act  = 0;
                m_data = 0;
                m_gap  = CW;
                m_und  = !m_last;
            end else if (m_gap > 0) begin
                m_gap--;
                if (m_gap == 0) m_done = 1;
            end
        end
    end

    always @(negedge CLK) begin
        chk("ACTIVE", ACTIVE, m_act);
        chk("DATA", DATA, m_data);
        chk("BUSY", BUSY, m_act || m_gap > 0);
        chk("FRAME_DONE", FRAME_DONE, m_done);
        chk("UNDERRUN", UNDERRUN, m_und);
        chk("P_READY", P_READY, m_ready());
    end

    // Pre-edge sampling of outputs; counts lag the displayed value by one edge.
    logic [31:0] cap = '0;
    int act_cnt = 0, done_cnt = 0, und_cnt = 0;
    always @(posedge CLK) begin
        if (ACTIVE) begin
            cap = {cap[30:0], DATA};
            act_cnt++;
        end
        if (FRAME_DONE) done_cnt++;
        if (UNDERRUN) und_cnt++;
    end

    task automatic send(input logic [DW-1:0] d, input logic l);
        int n;
        P_DATA = d; P_LAST = l; P_VALID = 1'b1;
        n = 0;
        while (!P_READY && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 100) chk("send_timeout", 1, 0);
        @(negedge CLK);
        P_VALID = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!FRAME_DONE && n < 200) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 200) chk("done_timeout", 1, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int a0, d0, u0, lat;
    logic [15:0] exp16;
    logic [7:0]  exp_96, exp_f0;
    logic        exp_first;

    initial begin
`ifdef SER_MSB_FIRST_EN
        exp16 = 16'h0180; exp_96 = 8'h96; exp_f0 = 8'hF0; exp_first = 1'b1;
`else
        exp16 = 16'h8001; exp_96 = 8'h69; exp_f0 = 8'h0F; exp_first = 1'b0;
`endif
        P_VALID = 0; P_DATA = '0; P_LAST = 0;
        RST = 1'b1;
        #1 RST = 1'b0;
        #1;
        chk("rst_ready", P_READY, 1);
        chk("rst_active", ACTIVE, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", FRAME_DONE, 0);
        @(negedge CLK); @(negedge CLK);
        #2 RST = 1'b1;
        @(negedge CLK);

        // Single word A5
        a0 = act_cnt; d0 = done_cnt; u0 = und_cnt;
        send(8'hA5, 1'b1);
        wait_done(lat);
        chk("single_latency", lat, DW + CW);
        @(negedge CLK);
        chk("single_bits", cap[7:0], 8'hA5);
        chk("single_active_len", act_cnt - a0, 8);
        chk("single_done_cnt", done_cnt - d0, 1);
        chk("single_under_cnt", und_cnt - u0, 0);

        // Back-to-back 01, 80(last)
        a0 = act_cnt;
        send(8'h01, 1'b0);
        send(8'h80, 1'b1);
        wait_done(lat);
        chk("b2b_latency", lat, DW + CW);
        @(negedge CLK);
        chk("b2b_bits", cap[15:0], exp16);
        chk("b2b_active_len", act_cnt - a0, 16);

        // Underrun on 3C
        a0 = act_cnt; d0 = done_cnt; u0 = und_cnt;
        send(8'h3C, 1'b0);
        wait_done(lat);
        chk("under_latency", lat, DW + CW);
        @(negedge CLK);
        chk("under_bits", cap[7:0], 8'h3C);
        chk("under_cnt", und_cnt - u0, 1);
        chk("under_done_cnt", done_cnt - d0, 1);
        chk("under_active_len", act_cnt - a0, 8);

        // Reset during bit 3
        d0 = done_cnt;
        send(8'hA5, 1'b1);
        repeat (3) @(negedge CLK);
        #2 RST = 1'b0;
        #1;
        chk("midrst_active", ACTIVE, 0);
        chk("midrst_data", DATA, 0);
        chk("midrst_busy", BUSY, 0);
        chk("midrst_ready", P_READY, 1);
        @(negedge CLK);
        #2 RST = 1'b1;
        repeat (20) @(negedge CLK);
        chk("midrst_no_done", done_cnt - d0, 0);
        send(8'h96, 1'b1);
        wait_done(lat);
        chk("post_rst_latency", lat, DW + CW);
        @(negedge CLK);
        chk("post_rst_bits", cap[7:0], exp_96);

        // Handshake in the FRAME_DONE cycle
        send(8'h0F, 1'b1);
        P_DATA = 8'hF0; P_LAST = 1'b1; P_VALID = 1'b1;
        lat = 0;
        while (!P_READY && lat < 100) begin
            @(negedge CLK);
            lat++;
        end
        chk("hs_done_wait", lat, DW + CW);
        chk("hs_done_pulse", FRAME_DONE, 1);
        @(negedge CLK);
        P_VALID = 1'b0;
        chk("hs_done_active", ACTIVE, 1);
        chk("hs_done_bit0", DATA, exp_first);
        wait_done(lat);
        @(negedge CLK);
        chk("hs_done_bits", cap[7:0], exp_f0);

        repeat (3) @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/crc_frame_serializer.md
# crc_frame_serializer

Byte-to-bit front end for the serial CRC stage. It accepts bytes over a valid/ready handshake and shifts each byte out on `DATA`, one bit per clock, with `ACTIVE` high for the whole frame. After the last byte it holds `ACTIVE` low for `CRC_WIDTH` cycles so the downstream CRC stage can emit its checksum uninterrupted. It then signals frame completion.

## Interface
- `DATA_WIDTH`, default 8: bits per input word.
- `CRC_WIDTH`, default 8: number of cycles the downstream CRC stage needs to shift out its result (post-frame gap length).
- `CLK`  in  1  clock; all logic on the rising edge.
- `RST`  in  1  asynchronous, active-low reset.
- `P_DATA`  in  DATA_WIDTH  parallel word to serialize.
- `P_VALID`  in  1  `P_DATA`/`P_LAST` are valid.
- `P_LAST`  in  1  this word ends the frame.
- `P_READY`  out  1  word accepted on the edge where `P_VALID & P_READY`; combinational from state.
- `ACTIVE`  out  1  registered; high while frame bits are on `DATA`; feeds CRC `ACTIVE`.
- `DATA`  out  1  registered serial bit; feeds CRC `DATA`.
- `BUSY`  out  1  registered; high in SHIFT and GAP.
- `FRAME_DONE`  out  1  registered one-cycle pulse at frame end.
- `UNDERRUN`  out  1  registered one-cycle pulse when a frame is force-terminated.

## Operation
- **Reset values:** state IDLE, `ACTIVE`=0, `DATA`=0, `BUSY`=0, `FRAME_DONE`=0, `UNDERRUN`=0, counters 0, `P_READY`=1.
- **States:** IDLE, SHIFT, GAP.
- **IDLE**
  - `P_READY`=1.
  - On handshake: load shift register with `P_DATA`, latch `last_q`=`P_LAST`, clear `bit_cnt`, go to SHIFT.
- **SHIFT**
  - Each cycle, register `ACTIVE`=1 and `DATA`=current output bit, shift the register, and increment `bit_cnt` (width `$clog2(DATA_WIDTH)`).
  - On the cycle emitting bit `DATA_WIDTH-1`:
    - If `last_q`=0: `P_READY`=1. A handshake reloads the register, clears `bit_cnt` and stays in SHIFT with no bubble in `ACTIVE`.
    - If `last_q`=0 and no `P_VALID` (underrun): the frame ends. Go to GAP and pulse `UNDERRUN` on the next edge. A frame must never pause, because `ACTIVE` low starts CRC emission.
    - If `last_q`=1: `P_READY`=0; go to GAP.
- **GAP**
  - `ACTIVE`=0, `DATA`=0, `P_READY`=0.
  - `gap_cnt` counts 0..`CRC_WIDTH-1`.
  - On the final count: go to IDLE, pulse `FRAME_DONE`, clear `BUSY`.
- **`P_READY` rule:** `P_READY` outside the two cases above is 0. Input changes while `P_READY`=0 are ignored.
- **Reset mid-frame:** immediate return to reset values, with no `FRAME_DONE` or `UNDERRUN` pulse. The partial frame is discarded; the CRC stage is reset by the same `RST`.
- **`FRAME_DONE` and next frame:** `FRAME_DONE` coincides with IDLE, so a handshake in that same cycle is legal and starts the next frame.

## Timing
- **Frame start:** handshake sampled at edge k → `ACTIVE`=1 with bit 0 on `DATA` from edge k until edge k+`DATA_WIDTH`.
- **Single-word frame:** `ACTIVE` high exactly `DATA_WIDTH` cycles, then low `CRC_WIDTH` cycles. `FRAME_DONE` is high for the one cycle after the gap, at edge k+`DATA_WIDTH`+`CRC_WIDTH`.
- **N-word frame:** `ACTIVE` high for N·`DATA_WIDTH` contiguous cycles.
- **Handshake latency:** 1 cycle from handshake to first bit on `DATA`.
- **Throughput:** 1 bit per clock during SHIFT. Frame overhead is `CRC_WIDTH` cycles.

## Configuration
- **`SER_MSB_FIRST_EN`**
  - Defined: bits leave MSB first; the register shifts left and `DATA` takes bit `DATA_WIDTH-1`.
  - Undefined (default): LSB first; the register shifts right and `DATA` takes bit 0.
  - Counts, handshake and timing are identical in both modes.

## Test plan
- **Single word, LSB first:** one word 0xA5 with `P_LAST`=1 → `DATA` = 1,0,1,0,0,1,0,1 for 8 cycles with `ACTIVE`=1, then 8 cycles `ACTIVE`=0, then `FRAME_DONE` pulse; `P_READY`=0 throughout SHIFT/GAP.
- **Back-to-back words:** 0x01, 0x80(last) presented back-to-back → `ACTIVE` high 16 contiguous cycles, `DATA` = 1,0×14,1; second handshake occurs on cycle 8 of the first word.
- **Underrun:** 0x3C with `P_LAST`=0, `P_VALID` dropped afterwards → 8 bits emitted, `UNDERRUN` pulses once, 8-cycle gap, `FRAME_DONE` pulses.
- **Reset mid-frame:** `RST` low during bit 3 → `ACTIVE`, `DATA`, `BUSY` are 0 immediately, `P_READY`=1, with no `FRAME_DONE`. A new frame after release serializes correctly.
- **Handshake with `FRAME_DONE`:** handshake asserted in the `FRAME_DONE` cycle → next frame's bit 0 appears on the following edge.
- **MSB-first mode:** with `SER_MSB_FIRST_EN` defined, 0xA5 → `DATA` = 1,0,1,0,0,1,0,1 (palindrome check), and 0x01 → 0×7 then 1.
